ex_result_buf: RTL and testbench

EX_RESULT_BUF -- requirements
Module: ex_result_buf

---
 rtl/ex_result_buf.sv | 132 +++++++++++++
 tb/tb_ex_result_buf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_buf.sv
// Execute-stage result buffer: 4-entry FIFO between the ALU and writeback, with a mispredict redirect pulse.
// Optional same-cycle bypass when empty is enabled by defining EX_RESULT_BUF_BYPASS_EN.
module ex_result_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_out,
    input  logic [DATA_W-1:0] in_out_wr,
    input  logic [4:0]        in_dest,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_ov,
    input  logic              in_mispredict,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_out,
    output logic [DATA_W-1:0] wb_out_wr,
    output logic [DATA_W-1:0] wb_pc,
    output logic [4:0]        wb_dest,
    output logic              wb_we,
    output logic              wb_exc,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc
);

    localparam logic [2:0] FULL_CNT = 3'd4;

    logic [DATA_W-1:0] ent_out    [4];
    logic [DATA_W-1:0] ent_out_wr [4];
    logic [DATA_W-1:0] ent_pc     [4];
    logic [4:0]        ent_dest   [4];
    logic              ent_ov     [4];

    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;

    logic              push;
    logic              store;
    logic              pop;
    logic              bypass;
    logic              head_vld;
    logic              take_redirect;

    logic              redirect_vld_p1;
    logic [DATA_W-1:0] redirect_pc_p1;

    // Branch delay slot: execution resumes two instructions past the branch.
    function automatic logic [DATA_W-1:0] redirect_target(input logic [DATA_W-1:0] pc);
        return pc + DATA_W'(8);
    endfunction

    function automatic logic gpr_we(input logic [4:0] dest, input logic ov);
        return (dest != 5'd0) && !ov;
    endfunction

`ifdef EX_RESULT_BUF_BYPASS_EN
    assign bypass = (count == 3'd0) && in_valid && wb_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready      = (count != FULL_CNT);
    assign head_vld      = (count != 3'd0);
    assign push          = in_valid && in_ready && !flush;
    assign store         = push && !bypass;
    assign pop           = head_vld && wb_ready && !flush;
    // A pulse already in flight suppresses the redirect of an immediately following mispredict.
    assign take_redirect = push && in_mispredict && !redirect_vld_p1;

    always_comb begin
        wb_valid  = head_vld;
        wb_out    = ent_out[rd_ptr];
        wb_out_wr = ent_out_wr[rd_ptr];
        wb_pc     = ent_pc[rd_ptr];
        wb_dest   = ent_dest[rd_ptr];
        wb_we     = head_vld && gpr_we(ent_dest[rd_ptr], ent_ov[rd_ptr]);
        wb_exc    = head_vld && ent_ov[rd_ptr];
        if (bypass) begin
            wb_valid  = 1'b1;
            wb_out    = in_out;
            wb_out_wr = in_out_wr;
            wb_pc     = in_pc;
            wb_dest   = in_dest;
            wb_we     = gpr_we(in_dest, in_ov);
            wb_exc    = in_ov;
        end
    end

    // Stage p1: FIFO bookkeeping and the registered redirect pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr          <= 2'd0;
            rd_ptr          <= 2'd0;
            count           <= 3'd0;
            redirect_vld_p1 <= 1'b0;
            redirect_pc_p1  <= '0;
        end else if (flush) begin
            wr_ptr          <= 2'd0;
            rd_ptr          <= 2'd0;
            count           <= 3'd0;
            redirect_vld_p1 <= 1'b0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            case ({store, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            redirect_vld_p1 <= take_redirect;
            if (take_redirect) redirect_pc_p1 <= redirect_target(in_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            ent_out[wr_ptr]    <= in_out;
            ent_out_wr[wr_ptr] <= in_out_wr;
            ent_pc[wr_ptr]     <= in_pc;
            ent_dest[wr_ptr]   <= in_dest;
            ent_ov[wr_ptr]     <= in_ov;
        end
    end

    assign redirect    = redirect_vld_p1;
    assign redirect_pc = redirect_pc_p1;

endmodule

// File: tb/tb_ex_result_buf.sv
// Randomized self-checking bench for ex_result_buf against a queue-based reference model.
module tb_ex_result_buf;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_out;
    logic [31:0] in_out_wr;
    logic [4:0]  in_dest;
    logic [31:0] in_pc;
    logic        in_ov;
    logic        in_mispredict;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_out;
    logic [31:0] wb_out_wr;
    logic [31:0] wb_pc;
    logic [4:0]  wb_dest;
    logic        wb_we;
    logic        wb_exc;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] out;
        logic [31:0] out_wr;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        ov;
    } ent_t;

    ent_t        mq[$];
    logic        m_redir = 1'b0;
    logic [31:0] m_rpc   = 32'h0;

    always #5 clk = ~clk;

    ex_result_buf #(.DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_out(in_out), .in_out_wr(in_out_wr), .in_dest(in_dest), .in_pc(in_pc),
        .in_ov(in_ov), .in_mispredict(in_mispredict), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_out(wb_out), .wb_out_wr(wb_out_wr), .wb_pc(wb_pc), .wb_dest(wb_dest),
        .wb_we(wb_we), .wb_exc(wb_exc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_bypass();
`ifdef EX_RESULT_BUF_BYPASS_EN
        return (mq.size() == 0) && in_valid && wb_ready && !flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drv(input logic v, input logic [31:0] o, input logic [4:0] d,
                       input logic [31:0] pc, input logic ov, input logic mis,
                       input logic rdy, input logic fl);
        in_valid = v; in_out = o; in_out_wr = ~o; in_dest = d; in_pc = pc;
        in_ov = ov; in_mispredict = mis; wb_ready = rdy; flush = fl;
    endtask

    // Compare against the model mid-cycle, then advance the model on the edge.
    task automatic cycle();
        logic bp;
        logic push;
        logic pop;
        @(negedge clk);
        bp = model_bypass();
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 4));
        chk("wb_valid", 32'(wb_valid), 32'(mq.size() != 0 || bp));
        if (bp) begin
            chk("wb_out_bp", wb_out, in_out);
            chk("wb_we_bp", 32'(wb_we), 32'(in_dest != 0 && !in_ov));
            chk("wb_exc_bp", 32'(wb_exc), 32'(in_ov));
        end else if (mq.size() != 0) begin
            chk("wb_out", wb_out, mq[0].out);
            chk("wb_out_wr", wb_out_wr, mq[0].out_wr);
            chk("wb_pc", wb_pc, mq[0].pc);
            chk("wb_dest", 32'(wb_dest), 32'(mq[0].dest));
            chk("wb_we", 32'(wb_we), 32'(mq[0].dest != 0 && !mq[0].ov));
            chk("wb_exc", 32'(wb_exc), 32'(mq[0].ov));
        end else begin
            chk("wb_we_idle", 32'(wb_we), 32'h0);
            chk("wb_exc_idle", 32'(wb_exc), 32'h0);
        end
        chk("redirect", 32'(redirect), 32'(m_redir));
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
        @(posedge clk);
        if (!resetn) begin
            mq.delete(); m_redir = 1'b0; m_rpc = 32'h0;
        end else if (flush) begin
            mq.delete(); m_redir = 1'b0;
        end else begin
            push = in_valid && (mq.size() < 4);
            pop  = (mq.size() != 0) && wb_ready;
            if (pop) void'(mq.pop_front());
            if (push && !bp) mq.push_back('{in_out, ~in_out, in_pc, in_dest, in_ov});
            if (push && in_mispredict && !m_redir) begin
                m_redir = 1'b1; m_rpc = in_pc + 32'd8;
            end else begin
                m_redir = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        cycle();
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        resetn = 1'b1;

        // Single result with a register write
        drv(1, 32'h22, 5, 32'h100, 0, 0, 1, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        chk("first_wb_valid", 32'(wb_valid), 32'h1);
        chk("first_wb_out", wb_out, 32'h22);
        chk("first_wb_we", 32'(wb_we), 32'h1);
        cycle();

        // Fill past capacity while stalled, then drain in order
        for (int i = 1; i <= 5; i++) begin
            drv(1, 32'(i), 5'(i), 32'h200 + 32'(i), 0, 0, 0, 0); cycle();
        end
        chk("full_in_ready", 32'(in_ready), 32'h0);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", wb_out, 32'(i));
            cycle();
        end
        chk("drain_empty", 32'(wb_valid), 32'h0);

        // Overflowing add raises an exception and suppresses the write
        drv(1, 32'h80000000, 3, 32'h300, 1, 0, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        chk("ov_exc", 32'(wb_exc), 32'h1);
        chk("ov_we", 32'(wb_we), 32'h0);
        cycle();

        // Back-to-back mispredicts: only the first redirects
        drv(1, 32'h1, 1, 32'hbfc00100, 0, 1, 1, 0); cycle();
        chk("redir_pulse", 32'(redirect), 32'h1);
        chk("redir_target", redirect_pc, 32'hbfc00108);
        drv(1, 32'h2, 1, 32'hbfc00200, 0, 1, 1, 0); cycle();
        chk("redir_second_ignored", 32'(redirect), 32'h0);
        drv(0, 0, 0, 0, 0, 0, 1, 0); cycle(); cycle();

        // Flush with a concurrent push discards everything
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h40 + 32'(i), 2, 32'h400, 0, 0, 0, 0); cycle();
        end
        drv(1, 32'h50, 2, 32'h500, 0, 1, 0, 1); cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_valid", 32'(wb_valid), 32'h0);
        chk("flush_redirect", 32'(redirect), 32'h0);
        cycle();

        // Full buffer with simultaneous pop and push: pop only
        for (int i = 0; i < 4; i++) begin
            drv(1, 32'h60 + 32'(i), 4, 32'h600, 0, 0, 0, 0); cycle();
        end
        drv(1, 32'h70, 4, 32'h700, 0, 0, 1, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("full_pop_ready", 32'(in_ready), 32'h1);
        chk("full_pop_head", wb_out, 32'h61);
        cycle();

        // Random traffic including occasional flush and mid-run reset
        for (int n = 0; n < 600; n++) begin
            drv($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
            resetn = ($urandom_range(0, 60) != 0);
            cycle();
        end
        resetn = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (6) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
